// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - instruction memory request/ack bus
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - sequential fetch front-end with redirect-flushed instruction queue
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  ifetch_queue_if.master               imem,
  input  logic                         hold,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [31:0]                  pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t            state;
  logic [31:0]       fpc;
  logic [31:0]       lost_addr;
  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       pc4_mem  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              push;
  logic              pop;

  always_comb begin
    inst_valid = (cnt != '0);
    pop        = inst_valid & ~hold & ~redirect;
    push       = (state == WAIT) & imem.imem_ack & ~redirect;
    cnt_next   = cnt + CNT_W'(push) - CNT_W'(pop);
    inst       = inst_valid ? inst_mem[rd_ptr] : 32'h0;
    pc4        = inst_valid ? pc4_mem[rd_ptr]  : 32'h0;
    count      = cnt;
  end

  // DISCARD keeps presenting the abandoned address until the memory acks it
  assign imem.imem_req  = (state != IDLE);
  assign imem.imem_addr = (state == DISCARD) ? lost_addr : fpc;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem.imem_data;
      pc4_mem[wr_ptr]  <= fpc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      lost_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (redirect) begin
        cnt    <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        cnt <= cnt_next;
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (redirect) begin
            fpc <= redirect_pc;
          end else if (cnt < FULL) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fpc <= redirect_pc;
            if (imem.imem_ack) begin
              state <= IDLE;
            end else begin
              lost_addr <= fpc;
              state     <= DISCARD;
            end
          end else if (imem.imem_ack) begin
            // chain the next fetch only if the queue still has room after this cycle
            fpc <= fpc + 32'd4;
            if (cnt_next >= FULL) begin
              state <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect) begin
            fpc <= redirect_pc;
          end
          if (imem.imem_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RPC    = 32'h0000_0000;
  localparam logic [31:0] WRAPPC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc4;
  logic [2:0]  count;

  logic        w_hold = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_pc4;
  logic [2:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wcnt    = 0;
  bit ack_block = 1'b0;
  bit chk_en    = 1'b0;

  ifetch_queue_if bus ();
  ifetch_queue_if wbus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) u_dut (
    .clk(clk), .rst(rst), .imem(bus), .hold(hold), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst), .pc4(pc4), .count(count)
  );

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAPPC)) u_wrap (
    .clk(clk), .rst(rst), .imem(wbus), .hold(w_hold), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc), .inst_valid(w_inst_valid), .inst(w_inst), .pc4(w_pc4), .count(w_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Instruction memory: acks after lat wait cycles, responses change just after the edge
  always @(posedge clk) begin
    #1;
    if (bus.imem_req && !ack_block) begin
      if (wcnt >= lat) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = memf(bus.imem_addr);
        wcnt = 0;
      end else begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
        wcnt++;
      end
    end else begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = 32'h0;
      if (!bus.imem_req) wcnt = 0;
    end
    wbus.imem_ack  = wbus.imem_req;
    wbus.imem_data = memf(wbus.imem_addr);
  end

  // Reference model: an instruction queue plus at most one pending request (none/live/abandoned)
  typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;
  localparam int P_NONE = 0, P_LIVE = 1, P_ABAND = 2;
  ent_t        q[$];
  int          pend;
  int          sz;
  bit          do_pop;
  logic [31:0] m_fpc;
  logic [31:0] p_addr;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_fpc  = RPC;
      p_addr = RPC;
      pend   = P_NONE;
    end else begin
      sz     = q.size();
      do_pop = (sz > 0) && !hold && !redirect;
      if (redirect) begin
        q.delete();
        m_fpc = redirect_pc;
        if (pend == P_LIVE) pend = bus.imem_ack ? P_NONE : P_ABAND;
        else if (pend == P_ABAND && bus.imem_ack) pend = P_NONE;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (pend == P_ABAND) begin
          if (bus.imem_ack) pend = P_NONE;
        end else if (pend == P_LIVE) begin
          if (bus.imem_ack) begin
            q.push_back('{memf(p_addr), p_addr + 32'd4});
            m_fpc = p_addr + 32'd4;
            if (q.size() < DEPTH) p_addr = m_fpc;
            else pend = P_NONE;
          end
        end else if (sz < DEPTH) begin
          pend   = P_LIVE;
          p_addr = m_fpc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 32'(bus.imem_req), 32'(pend != P_NONE));
      if (pend != P_NONE) check("addr", bus.imem_addr, p_addr);
      check("valid", 32'(inst_valid), 32'(q.size() != 0));
      check("inst", inst, (q.size() != 0) ? q[0].inst : 32'h0);
      check("pc4", pc4, (q.size() != 0) ? q[0].pc4 : 32'h0);
      check("count", 32'(count), 32'(q.size()));
    end
  end

  task automatic do_reset(input int l, input bit h);
    rst = 1'b1;
    lat = l;
    hold = h;
    redirect = 1'b0;
    ack_block = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    bus.imem_ack = 1'b0; bus.imem_data = 32'h0;
    wbus.imem_ack = 1'b0; wbus.imem_data = 32'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_addr", bus.imem_addr, 32'h0000_0000);
    check("rst_waddr", wbus.imem_addr, 32'hFFFF_FFF8);
    check("rst_wreq", 32'(wbus.imem_req), 32'h0);

    // zero-wait memory, back-to-back fetch; wrap instance runs alongside
    rst = 1'b0;
    @(negedge clk);
    check("zw_n1_req", 32'(bus.imem_req), 32'h1);
    check("zw_n1_addr", bus.imem_addr, 32'h0);
    check("zw_n1_valid", 32'(inst_valid), 32'h0);
    check("wrap_a0", wbus.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    check("zw_n2_valid", 32'(inst_valid), 32'h1);
    check("zw_n2_pc4", pc4, 32'h4);
    check("zw_n2_inst", inst, 32'hFFFF_0000);
    check("zw_n2_addr", bus.imem_addr, 32'h4);
    check("wrap_a1", wbus.imem_addr, 32'hFFFF_FFFC);
    check("wrap_p0", w_pc4, 32'hFFFF_FFFC);
    @(negedge clk);
    check("zw_n3_addr", bus.imem_addr, 32'h8);
    check("zw_n3_pc4", pc4, 32'h8);
    check("wrap_a2", wbus.imem_addr, 32'h0);
    check("wrap_p1", w_pc4, 32'h0);
    @(negedge clk);
    check("zw_n4_pc4", pc4, 32'hC);
    check("wrap_p2", w_pc4, 32'h4);
    repeat (4) @(negedge clk);

    // hold with a 1-wait memory fills the queue and stops requests
    do_reset(1, 1'b1);
    repeat (12) @(negedge clk);
    check("full_count", 32'(count), 32'h4);
    check("full_req", 32'(bus.imem_req), 32'h0);
    hold = 1'b0;
    check("drain_pc4_0", pc4, 32'h4);
    @(negedge clk);
    check("drain_pc4_1", pc4, 32'h8);
    @(negedge clk);
    check("drain_pc4_2", pc4, 32'hC);
    @(negedge clk);
    check("drain_pc4_3", pc4, 32'h10);
    for (int k = 0; k < 50 && !bus.imem_req; k++) @(negedge clk);
    check("resume_req", 32'(bus.imem_req), 32'h1);
    check("resume_addr", bus.imem_addr, 32'h10);
    repeat (4) @(negedge clk);

    // redirect while waiting on a slow memory with three entries queued
    do_reset(2, 1'b1);
    for (int k = 0; k < 100 && !(count == 3'd3 && bus.imem_req && !bus.imem_ack); k++) @(negedge clk);
    check("rd_setup", 32'(count == 3'd3 && bus.imem_req && !bus.imem_ack), 32'h1);
    ack_block = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    check("rd_valid", 32'(inst_valid), 32'h0);
    check("rd_count", 32'(count), 32'h0);
    check("rd_abandoned", bus.imem_addr, 32'hC);
    ack_block = 1'b0;
    hold = 1'b0;
    for (int k = 0; k < 50 && bus.imem_req; k++) @(negedge clk);
    for (int k = 0; k < 50 && !bus.imem_req; k++) @(negedge clk);
    check("rd_new_addr", bus.imem_addr, 32'h40);
    for (int k = 0; k < 50 && !inst_valid; k++) @(negedge clk);
    check("rd_first_pc4", pc4, 32'h44);
    check("rd_first_inst", inst, 32'hFFBF_0040);
    repeat (3) @(negedge clk);

    // redirect in the same cycle as an ack
    do_reset(0, 1'b0);
    repeat (4) @(negedge clk);
    check("ra_coincident", 32'(bus.imem_req && bus.imem_ack), 32'h1);
    redirect = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    check("ra_req", 32'(bus.imem_req), 32'h0);
    check("ra_count", 32'(count), 32'h0);
    @(negedge clk);
    check("ra_addr", bus.imem_addr, 32'h80);
    for (int k = 0; k < 50 && !inst_valid; k++) @(negedge clk);
    check("ra_pc4", pc4, 32'h84);
    repeat (3) @(negedge clk);

    // reset while a request is outstanding
    do_reset(3, 1'b1);
    for (int k = 0; k < 100 && !(count == 3'd2 && bus.imem_req); k++) @(negedge clk);
    check("mr_setup", 32'(count == 3'd2 && bus.imem_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mr_req", 32'(bus.imem_req), 32'h0);
    check("mr_count", 32'(count), 32'h0);
    check("mr_inst", inst, 32'h0);
    rst = 1'b0;
    hold = 1'b0;
    for (int k = 0; k < 50 && !bus.imem_req; k++) @(negedge clk);
    check("mr_restart", bus.imem_addr, 32'h0);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch front-end for the 5-stage pipeline. It sits between the instruction memory and the IF/ID pipeline register, and feeds the decode stage.
- Issues sequential word fetches to a variable-latency instruction memory over a req/ack handshake. Buffers up to DEPTH fetched instructions, each paired with its PC+4.
- Decode drains the buffer in order, honouring the pipeline stall. A taken branch or jump redirects the fetch PC and flushes the buffer.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  32  byte address of the requested word; stable while imem_req=1
imem_ack  in  1  imem_data valid this cycle; completes the outstanding request
imem_data  in  32  fetched instruction word
hold  in  1  decode stall (stall_s1_s2); head entry not consumed
redirect  in  1  taken branch/jump (pcsrc | jump_s4)
redirect_pc  in  32  new fetch PC (baddr_s4 / jaddr_s4)
inst_valid  out  1  head entry present
inst  out  32  head instruction; 32'h0 (NOP) when inst_valid=0
pc4  out  32  head PC+4; 32'h0 when inst_valid=0
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- State:
  - fpc (32-bit fetch PC)
  - circular buffer with rd_ptr/wr_ptr modulo DEPTH
  - count
  - FSM {IDLE, WAIT, DISCARD}
- Reset (rst=1 at edge): fpc=RESET_PC, count=0, pointers=0, FSM=IDLE. Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, pc4=0, count=0.
- imem_req=1 exactly when FSM is WAIT or DISCARD. imem_addr=fpc in WAIT; it holds the abandoned address in DISCARD.
- At most one outstanding request. imem_ack while imem_req=0 is ignored.
- pop = inst_valid & ~hold & ~redirect. Outputs inst/pc4/inst_valid are combinational from the head entry and count.
- push = (FSM==WAIT) & imem_ack & ~redirect. It writes {imem_data, fpc+4} at wr_ptr; fpc<=fpc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
- Counting: push and pop in the same cycle leave count unchanged. The entry pushed this cycle is visible at the head no earlier than the next cycle.
- IDLE:
  - redirect: fpc<=redirect_pc, stay IDLE.
  - else if count<DEPTH: -> WAIT (imem_req high next cycle).
  - else stay.
- WAIT:
  - redirect & imem_ack: data dropped, fpc<=redirect_pc, -> IDLE.
  - redirect & ~imem_ack: fpc<=redirect_pc, -> DISCARD.
  - imem_ack: push. Stay WAIT if (count+1-pop)<DEPTH, giving 1 fetch/cycle with a zero-wait memory; else -> IDLE.
  - no ack: stay; address unchanged.
- DISCARD:
  - imem_ack: data dropped, -> IDLE.
  - redirect: fpc<=redirect_pc, stay DISCARD.
- Redirect (any state): count<=0 and rd_ptr<=wr_ptr in the same edge. inst_valid=0 the following cycle.
- Redirect has priority over push, pop and hold.
- Full (count==DEPTH): no new request is issued. An in-flight ack can never overflow, because only one request is outstanding and WAIT is entered only when count<DEPTH.
- Empty: inst_valid=0, inst=0; decode sees a bubble. hold with an empty queue has no effect.
- Reset mid-request drops imem_req next cycle. The instruction memory shares rst and abandons the request.

Test Plan:
- Reset release with zero-wait memory (ack same cycle as req): requests at 0x0, 0x4, 0x8 on consecutive cycles. inst_valid rises 2 cycles after reset release, with pc4=0x4 and inst=mem[0]. Then one instruction per cycle with hold=0.
- hold=1 held for 10 cycles with a 1-wait memory: count saturates at DEPTH=4 and imem_req stays 0. Release hold: entries with pc4=0x4,0x8,0xC,0x10 emerge in order, then fetch resumes at 0x10.
- redirect with redirect_pc=0x40 while count=3 and in WAIT with no ack: next cycle inst_valid=0 and count=0. The late ack is discarded. Next request has imem_addr=0x40, and the first delivered entry has pc4=0x44.
- redirect coincident with imem_ack in WAIT: no push occurs, FSM goes to IDLE, and the next imem_addr equals redirect_pc.
- Wrap: RESET_PC=32'hFFFF_FFF8. Requests at 0xFFFFFFF8, 0xFFFFFFFC, 0x0; pc4 values 0xFFFFFFFC, 0x0, 0x4.
- rst asserted in WAIT with count=2: next cycle imem_req=0, count=0, inst=0. Fetch restarts at RESET_PC.
